// File: rtl/prefetch_byte_queue.sv
// rtl/prefetch_byte_queue.sv - circular byte FIFO between instruction fetch and predecode
module prefetch_byte_queue #(
  parameter int DEPTH     = 32,
  parameter int IN_BYTES  = 4,
  parameter int OUT_BYTES = 8,
  localparam int PW  = $clog2(DEPTH),
  localparam int CW  = $clog2(DEPTH) + 1,
  localparam int PCW = $clog2(IN_BYTES) + 1,
  localparam int OLW = $clog2(OUT_BYTES) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push_valid,
  input  logic [PCW-1:0]         push_count,
  input  logic [8*IN_BYTES-1:0]  push_data,
  output logic                   push_ready,
  output logic [8*OUT_BYTES-1:0] win_data,
  output logic [OLW-1:0]         win_avail,
  input  logic [OLW-1:0]         pop_len,
  output logic [CW-1:0]          count,
  output logic                   proto_err
);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          push_legal;
  logic          push_err;
  logic          pop_err;
  logic          push_fire;
  logic          pop_fire;
  logic [CW-1:0] push_n;
  logic [CW-1:0] pop_n;

  // Readiness and window size come from registered occupancy only.
  always_comb begin
    push_ready = (CW'(DEPTH) - count) >= CW'(IN_BYTES);
    win_avail  = (count >= CW'(OUT_BYTES)) ? OLW'(OUT_BYTES) : OLW'(count);
    push_legal = (push_count != '0) && (push_count <= PCW'(IN_BYTES));
    push_err   = push_valid && !push_legal;
    pop_err    = pop_len > win_avail;
    push_fire  = push_valid && push_legal && push_ready && !flush;
    pop_fire   = (pop_len != '0) && !pop_err && !flush;
    push_n     = push_fire ? CW'(push_count) : '0;
    pop_n      = pop_fire ? CW'(pop_len) : '0;
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < OUT_BYTES; i++) begin
      if (OLW'(i) < win_avail) win_data[8*i +: 8] = mem[rd_ptr + PW'(i)];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_BYTES; i++) begin
      if (push_fire && (PCW'(i) < push_count)) mem[wr_ptr + PW'(i)] <= push_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      proto_err <= 1'b0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      proto_err <= 1'b0;
    end else begin
      rd_ptr    <= rd_ptr + PW'(pop_n);
      wr_ptr    <= wr_ptr + PW'(push_n);
      count     <= count + push_n - pop_n;
      proto_err <= push_err || pop_err;
    end
  end

endmodule

// File: tb/tb_prefetch_byte_queue.sv
// tb/tb_prefetch_byte_queue.sv - self-checking bench for prefetch_byte_queue
module tb_prefetch_byte_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        push_valid = 1'b0;
  logic [2:0]  push_count = '0;
  logic [31:0] push_data = '0;
  logic        push_ready;
  logic [63:0] win_data;
  logic [3:0]  win_avail;
  logic [3:0]  pop_len = '0;
  logic [5:0]  count;
  logic        proto_err;

  int checks = 0;
  int failures = 0;
  logic [7:0] mq[$];
  logic       m_err = 1'b0;

  typedef struct {
    logic        fl;
    logic        pv;
    logic [2:0]  pc;
    logic [31:0] pd;
    logic [3:0]  pl;
    int          exp_count;
    int          exp_avail;
    logic        exp_err;
    logic [31:0] exp_win;
  } vec_t;

  vec_t vecs [17];

  prefetch_byte_queue dut (
    .clk(clk), .rst(rst), .flush(flush), .push_valid(push_valid),
    .push_count(push_count), .push_data(push_data), .push_ready(push_ready),
    .win_data(win_data), .win_avail(win_avail), .pop_len(pop_len),
    .count(count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard view: the byte queue model holds what should sit at the head.
  task automatic check_model();
    int sz;
    int av;
    logic [63:0] ew;
    sz = mq.size();
    av = (sz > 8) ? 8 : sz;
    ew = '0;
    for (int i = 0; i < av; i++) ew[8*i +: 8] = mq[i];
    chk("count", 64'(count), 64'(sz));
    chk("win_avail", 64'(win_avail), 64'(av));
    chk("push_ready", 64'(push_ready), 64'((32 - sz) >= 4));
    chk("proto_err", 64'(proto_err), 64'(m_err));
    chk("win_data", win_data, ew);
  endtask

  task automatic step(input logic fl, input logic pv, input logic [2:0] pc,
                      input logic [31:0] pd, input logic [3:0] pl);
    int sz;
    int av;
    logic rdy;
    logic perr;
    logic oerr;
    flush = fl; push_valid = pv; push_count = pc; push_data = pd; pop_len = pl;
    sz = mq.size();
    av = (sz > 8) ? 8 : sz;
    rdy = (32 - sz) >= 4;
    if (fl) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      perr = pv && (pc == 0 || pc > 4);
      oerr = int'(pl) > av;
      m_err = perr || oerr;
      if (!oerr) for (int i = 0; i < int'(pl); i++) void'(mq.pop_front());
      if (pv && !perr && rdy) for (int i = 0; i < int'(pc); i++) mq.push_back(pd[8*i +: 8]);
    end
    @(posedge clk);
    #1;
    flush = 1'b0; push_valid = 1'b0; push_count = '0; push_data = '0; pop_len = '0;
    check_model();
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 3'd4, 32'h00441F0F, 4'd0, 4, 4, 1'b0, 32'h00441F0F};
    vecs[1]  = '{1'b1, 1'b1, 3'd4, 32'hDEADBEEF, 4'd2, 0, 0, 1'b0, 32'h00000000};
    vecs[2]  = '{1'b0, 1'b1, 3'd4, 32'h03020100, 4'd0, 4, 4, 1'b0, 32'h03020100};
    vecs[3]  = '{1'b0, 1'b1, 3'd4, 32'h07060504, 4'd0, 8, 8, 1'b0, 32'h03020100};
    vecs[4]  = '{1'b0, 1'b1, 3'd4, 32'h0B0A0908, 4'd0, 12, 8, 1'b0, 32'h03020100};
    vecs[5]  = '{1'b0, 1'b0, 3'd0, 32'h00000000, 4'd3, 9, 8, 1'b0, 32'h06050403};
    vecs[6]  = '{1'b0, 1'b0, 3'd0, 32'h00000000, 4'd6, 3, 3, 1'b0, 32'h000B0A09};
    vecs[7]  = '{1'b0, 1'b0, 3'd0, 32'h00000000, 4'd5, 3, 3, 1'b1, 32'h000B0A09};
    vecs[8]  = '{1'b0, 1'b0, 3'd0, 32'h00000000, 4'd0, 3, 3, 1'b0, 32'h000B0A09};
    vecs[9]  = '{1'b0, 1'b1, 3'd0, 32'hFFFFFFFF, 4'd0, 3, 3, 1'b1, 32'h000B0A09};
    vecs[10] = '{1'b0, 1'b0, 3'd0, 32'h00000000, 4'd0, 3, 3, 1'b0, 32'h000B0A09};
    vecs[11] = '{1'b0, 1'b1, 3'd5, 32'h11223344, 4'd0, 3, 3, 1'b1, 32'h000B0A09};
    vecs[12] = '{1'b0, 1'b1, 3'd2, 32'h0000EEDD, 4'd1, 4, 4, 1'b0, 32'hEEDD0B0A};
    vecs[13] = '{1'b0, 1'b0, 3'd0, 32'h00000000, 4'd4, 0, 0, 1'b0, 32'h00000000};
    vecs[14] = '{1'b0, 1'b0, 3'd0, 32'h00000000, 4'd1, 0, 0, 1'b1, 32'h00000000};
    vecs[15] = '{1'b0, 1'b1, 3'd1, 32'h000000AB, 4'd2, 1, 1, 1'b1, 32'h000000AB};
    vecs[16] = '{1'b0, 1'b0, 3'd0, 32'h00000000, 4'd1, 0, 0, 1'b0, 32'h00000000};

    #12;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_avail", 64'(win_avail), 64'd0);
    chk("reset_ready", 64'(push_ready), 64'd1);
    chk("reset_err", 64'(proto_err), 64'd0);
    chk("reset_win", win_data, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int v = 0; v < 17; v++) begin
      step(vecs[v].fl, vecs[v].pv, vecs[v].pc, vecs[v].pd, vecs[v].pl);
      chk($sformatf("vec%0d_count", v), 64'(count), 64'(vecs[v].exp_count));
      chk($sformatf("vec%0d_avail", v), 64'(win_avail), 64'(vecs[v].exp_avail));
      chk($sformatf("vec%0d_err", v), 64'(proto_err), 64'(vecs[v].exp_err));
      chk($sformatf("vec%0d_win", v), 64'(win_data[31:0]), 64'(vecs[v].exp_win));
    end

    // Fill to the push_ready threshold and past it.
    step(1'b1, 1'b0, 3'd0, 32'h0, 4'd0);
    for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 3'd4, 32'h10101010 * k, 4'd0);
    chk("full28_count", 64'(count), 64'd28);
    chk("full28_ready", 64'(push_ready), 64'd1);
    step(1'b0, 1'b1, 3'd1, 32'h000000C1, 4'd0);
    chk("full29_ready", 64'(push_ready), 64'd0);
    step(1'b0, 1'b1, 3'd4, 32'hC5C4C3C2, 4'd0);
    chk("stall29_count", 64'(count), 64'd29);
    chk("stall29_err", 64'(proto_err), 64'd0);
    step(1'b0, 1'b0, 3'd0, 32'h0, 4'd1);
    step(1'b0, 1'b1, 3'd4, 32'hD3D2D1D0, 4'd0);
    chk("full32_count", 64'(count), 64'd32);
    step(1'b0, 1'b1, 3'd4, 32'hE3E2E1E0, 4'd0);
    chk("stall32_count", 64'(count), 64'd32);

    // Park both pointers at 30 with the queue empty, then straddle the wrap.
    step(1'b1, 1'b0, 3'd0, 32'h0, 4'd0);
    for (int k = 0; k < 7; k++) step(1'b0, 1'b1, 3'd4, 32'h01020304 + k, 4'd0);
    step(1'b0, 1'b1, 3'd2, 32'h00007766, 4'd0);
    step(1'b0, 1'b0, 3'd0, 32'h0, 4'd8);
    step(1'b0, 1'b0, 3'd0, 32'h0, 4'd8);
    step(1'b0, 1'b0, 3'd0, 32'h0, 4'd8);
    step(1'b0, 1'b0, 3'd0, 32'h0, 4'd6);
    chk("wrap_empty", 64'(count), 64'd0);
    step(1'b0, 1'b1, 3'd4, 32'hA3A2A1A0, 4'd0);
    chk("wrap_win4", 64'(win_data[31:0]), 64'hA3A2A1A0);
    step(1'b0, 1'b1, 3'd4, 32'hB3B2B1B0, 4'd2);
    chk("wrap_count6", 64'(count), 64'd6);
    chk("wrap_win6", win_data, 64'h0000B3B2B1B0A3A2);

    // Asynchronous reset between edges.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_avail", 64'(win_avail), 64'd0);
    chk("async_ready", 64'(push_ready), 64'd1);
    chk("async_count", 64'(count), 64'd0);
    mq.delete();
    m_err = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int n = 0; n < 300; n++) begin
      int av;
      logic [2:0] pc;
      logic [3:0] pl;
      av = (mq.size() > 8) ? 8 : mq.size();
      pc = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
      pl = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(0, av));
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, pc, $urandom, pl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
